// File: rtl/axil_lite_exdes_loopback.sv
// AXI4-Lite loopback example design: write/read-back traffic master, monitor tap and register-memory slave on one bus.
// Each transaction takes at least 2 cycles (accept, then response); slv_stall only delays address/data acceptance.
module axil_lite_exdes_loopback #(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                NUM_TXN   = 8,
    parameter int                MEM_DEPTH = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              start,
    input  logic              slv_stall,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [7:0]        wr_count,
    output logic [7:0]        rd_count,
    output logic [7:0]        err_count,
    output logic              mon_wr_valid,
    output logic [ADDR_W-1:0] mon_wr_addr,
    output logic [DATA_W-1:0] mon_wr_data,
    output logic              mon_rd_valid,
    output logic [ADDR_W-1:0] mon_rd_addr,
    output logic [DATA_W-1:0] mon_rd_data
);
    localparam int         IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [7:0] LAST  = 8'(NUM_TXN - 1);

    typedef enum logic [2:0] {S_IDLE, S_WR, S_WRESP, S_RD, S_RDATA, S_DONE} state_t;
    state_t state, state_nx;

    logic [7:0]        idx;
    logic              aw_sent, w_sent;
    logic [ADDR_W-1:0] awaddr, araddr, txn_addr;
    logic [DATA_W-1:0] wdata, rdata, txn_data;
    logic              awvalid, awready, wvalid, wready, bvalid, bready;
    logic              arvalid, arready, rvalid, rready;
    logic [1:0]        bresp, rresp;
    logic              aw_hs, w_hs, b_hs, ar_hs, r_hs, is_last;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Master side of the bus
    assign txn_addr = BASE_ADDR + ADDR_W'({idx, 2'b00});
    assign txn_data = DATA_W'(32'hC0DE_0000 | 32'(idx));
    assign awvalid  = (state == S_WR) && !aw_sent;
    assign wvalid   = (state == S_WR) && !w_sent;
    assign awaddr   = txn_addr;
    assign wdata    = txn_data;
    assign bready   = (state == S_WRESP);
    assign arvalid  = (state == S_RD);
    assign araddr   = txn_addr;
    assign rready   = (state == S_RDATA);

    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid && wready;
    assign b_hs    = bvalid && bready;
    assign ar_hs   = arvalid && arready;
    assign r_hs    = rvalid && rready;
    assign is_last = (idx == LAST);

    always_ff @(posedge aclk) begin
        if (aresetn) state <= S_IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:  if (start) state_nx = S_WR;
            S_WR:    if ((aw_sent || aw_hs) && (w_sent || w_hs)) state_nx = S_WRESP;
            S_WRESP: if (b_hs) state_nx = is_last ? S_RD : S_WR;
            S_RD:    if (ar_hs) state_nx = S_RDATA;
            S_RDATA: if (r_hs) state_nx = is_last ? S_DONE : S_RD;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (aresetn) begin
            idx       <= '0;
            aw_sent   <= 1'b0;
            w_sent    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            wr_count  <= '0;
            rd_count  <= '0;
            err_count <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    busy      <= 1'b1;
                    done      <= 1'b0;
                    wr_count  <= '0;
                    rd_count  <= '0;
                    err_count <= '0;
                    idx       <= '0;
                end
                S_WR: begin
                    if (state_nx == S_WRESP) begin
                        aw_sent <= 1'b0;
                        w_sent  <= 1'b0;
                    end else begin
                        if (aw_hs) aw_sent <= 1'b1;
                        if (w_hs)  w_sent  <= 1'b1;
                    end
                end
                S_WRESP: if (b_hs) begin
                    wr_count <= sat_inc(wr_count);
                    if (bresp != 2'b00) err_count <= sat_inc(err_count);
                    idx <= is_last ? 8'd0 : idx + 8'd1;
                end
                S_RDATA: if (r_hs) begin
                    rd_count <= sat_inc(rd_count);
                    if (rresp != 2'b00 || rdata != txn_data) err_count <= sat_inc(err_count);
                    if (!is_last) idx <= idx + 8'd1;
                end
                S_DONE: begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign pass = done && (err_count == 8'd0);

    // Slave: word-addressed register memory, AW and W always accepted together
    logic [DATA_W-1:0] mem [MEM_DEPTH];
    logic [ADDR_W-1:0] wr_word, rd_word;
    logic              wr_in_range, rd_in_range;

    assign wr_word     = (awaddr - BASE_ADDR) >> 2;
    assign rd_word     = (araddr - BASE_ADDR) >> 2;
    assign wr_in_range = wr_word < ADDR_W'(MEM_DEPTH);
    assign rd_in_range = rd_word < ADDR_W'(MEM_DEPTH);
    assign awready     = awvalid && wvalid && !slv_stall && !bvalid;
    assign wready      = awready;
    assign arready     = arvalid && !slv_stall && !rvalid;

    always_ff @(posedge aclk) begin
        if (aresetn) begin
            for (int k = 0; k < MEM_DEPTH; k++) mem[k] <= '0;
            bvalid <= 1'b0;
            bresp  <= 2'b00;
            rvalid <= 1'b0;
            rresp  <= 2'b00;
            rdata  <= '0;
        end else begin
            if (b_hs) bvalid <= 1'b0;
            if (aw_hs) begin
                bvalid <= 1'b1;
                if (wr_in_range) begin
                    mem[wr_word[IDX_W-1:0]] <= wdata;
                    bresp <= 2'b00;
                end else begin
                    bresp <= 2'b10;
                end
            end
            if (r_hs) rvalid <= 1'b0;
            if (ar_hs) begin
                rvalid <= 1'b1;
                rdata  <= rd_in_range ? mem[rd_word[IDX_W-1:0]] : '0;
                rresp  <= rd_in_range ? 2'b00 : 2'b10;
            end
        end
    end

    // Monitor tap: remembers address/data at acceptance, reports one cycle after the response handshake
    logic [ADDR_W-1:0] tap_awaddr, tap_araddr;
    logic [DATA_W-1:0] tap_wdata;

    always_ff @(posedge aclk) begin
        if (aresetn) begin
            tap_awaddr   <= '0;
            tap_araddr   <= '0;
            tap_wdata    <= '0;
            mon_wr_valid <= 1'b0;
            mon_wr_addr  <= '0;
            mon_wr_data  <= '0;
            mon_rd_valid <= 1'b0;
            mon_rd_addr  <= '0;
            mon_rd_data  <= '0;
        end else begin
            mon_wr_valid <= b_hs;
            mon_rd_valid <= r_hs;
            if (aw_hs) tap_awaddr <= awaddr;
            if (w_hs)  tap_wdata  <= wdata;
            if (ar_hs) tap_araddr <= araddr;
            if (b_hs) begin
                mon_wr_addr <= tap_awaddr;
                mon_wr_data <= tap_wdata;
            end
            if (r_hs) begin
                mon_rd_addr <= tap_araddr;
                mon_rd_data <= rdata;
            end
        end
    end
endmodule

// File: tb/tb_axil_lite_exdes_loopback.sv
// Bench for axil_lite_exdes_loopback: default instance plus a NUM_TXN=20 instance for the out-of-range case.
module tb_axil_lite_exdes_loopback;
    logic clk = 1'b0;
    logic aresetn, start, start2, slv_stall;

    logic        busy, done, pass, mon_wr_valid, mon_rd_valid;
    logic [7:0]  wr_count, rd_count, err_count;
    logic [31:0] mon_wr_addr, mon_wr_data, mon_rd_addr, mon_rd_data;

    logic        busy2, done2, pass2, mon_wr_valid2, mon_rd_valid2;
    logic [7:0]  wr_count2, rd_count2, err_count2;
    logic [31:0] mon_wr_addr2, mon_wr_data2, mon_rd_addr2, mon_rd_data2;

    always #5 clk = ~clk;

    axil_lite_exdes_loopback dut (
        .aclk(clk), .aresetn(aresetn), .start(start), .slv_stall(slv_stall),
        .busy(busy), .done(done), .pass(pass),
        .wr_count(wr_count), .rd_count(rd_count), .err_count(err_count),
        .mon_wr_valid(mon_wr_valid), .mon_wr_addr(mon_wr_addr), .mon_wr_data(mon_wr_data),
        .mon_rd_valid(mon_rd_valid), .mon_rd_addr(mon_rd_addr), .mon_rd_data(mon_rd_data)
    );

    axil_lite_exdes_loopback #(.NUM_TXN(20), .MEM_DEPTH(16)) dut20 (
        .aclk(clk), .aresetn(aresetn), .start(start2), .slv_stall(slv_stall),
        .busy(busy2), .done(done2), .pass(pass2),
        .wr_count(wr_count2), .rd_count(rd_count2), .err_count(err_count2),
        .mon_wr_valid(mon_wr_valid2), .mon_wr_addr(mon_wr_addr2), .mon_wr_data(mon_wr_data2),
        .mon_rd_valid(mon_rd_valid2), .mon_rd_addr(mon_rd_addr2), .mon_rd_data(mon_rd_data2)
    );

    typedef struct {
        bit          is_rd;
        logic [31:0] addr;
        logic [31:0] data;
    } ev_t;

    typedef struct {
        int stall;
        bit restart_busy;
        int exp_wr;
        int exp_rd;
        int exp_err;
        bit exp_pass;
    } vec_t;

    ev_t q1[$];
    ev_t q2[$];
    int  checks = 0;
    int  fails  = 0;
    int  mon_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Expected monitor stream for one run of n transactions against a 16-word slave
    task automatic push_run(input int which, input int n);
        ev_t e;
        for (int i = 0; i < n; i++) begin
            e.is_rd = 1'b0; e.addr = 32'(4 * i); e.data = 32'hC0DE_0000 | 32'(i);
            if (which == 0) q1.push_back(e); else q2.push_back(e);
        end
        for (int i = 0; i < n; i++) begin
            e.is_rd = 1'b1; e.addr = 32'(4 * i);
            e.data = (i < 16) ? (32'hC0DE_0000 | 32'(i)) : 32'h0;
            if (which == 0) q1.push_back(e); else q2.push_back(e);
        end
    endtask

    task automatic sb_pop(input int which, input bit is_rd, input logic [31:0] a, input logic [31:0] d);
        ev_t e;
        bit  have;
        have = 1'b0;
        if (which == 0 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
        if (which == 1 && q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
        checks++;
        if (!have) begin
            fails++;
            $display("FAIL sb%0d_unexpected: got rd=%0d addr=%h data=%h, expected no event", which, is_rd, a, d);
        end else if (e.is_rd != is_rd || e.addr !== a || e.data !== d) begin
            fails++;
            $display("FAIL sb%0d_event: got rd=%0d addr=%h data=%h, expected rd=%0d addr=%h data=%h",
                     which, is_rd, a, d, e.is_rd, e.addr, e.data);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (mon_wr_valid)  begin mon_seen++; sb_pop(0, 1'b0, mon_wr_addr, mon_wr_data); end
        if (mon_rd_valid)  begin mon_seen++; sb_pop(0, 1'b1, mon_rd_addr, mon_rd_data); end
        if (mon_wr_valid2) sb_pop(1, 1'b0, mon_wr_addr2, mon_wr_data2);
        if (mon_rd_valid2) sb_pop(1, 1'b1, mon_rd_addr2, mon_rd_data2);
    endtask

    task automatic wait_done(input int which, input string name);
        int n;
        n = 0;
        while (((which == 0) ? !done : !done2) && n < 1000) begin tick(); n++; end
        check({name, "_done_in_time"}, (which == 0) ? 32'(done) : 32'(done2), 32'd1);
    endtask

    vec_t vecs[4];

    initial begin
        vecs[0] = '{stall: 0,  restart_busy: 1'b0, exp_wr: 8, exp_rd: 8, exp_err: 0, exp_pass: 1'b1};
        vecs[1] = '{stall: 20, restart_busy: 1'b0, exp_wr: 8, exp_rd: 8, exp_err: 0, exp_pass: 1'b1};
        vecs[2] = '{stall: 0,  restart_busy: 1'b1, exp_wr: 8, exp_rd: 8, exp_err: 0, exp_pass: 1'b1};
        vecs[3] = '{stall: 0,  restart_busy: 1'b0, exp_wr: 8, exp_rd: 8, exp_err: 0, exp_pass: 1'b1};

        aresetn = 1'b1; start = 1'b0; start2 = 1'b0; slv_stall = 1'b0;
        repeat (3) tick();
        aresetn = 1'b0;
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pass", 32'(pass), 32'd0);
        check("rst_counts", {8'h0, wr_count, rd_count, err_count}, 32'd0);
        check("rst_mon", {30'd0, mon_wr_valid, mon_rd_valid}, 32'd0);

        // Table-driven runs; entries after the first also exercise restart after done
        for (int v = 0; v < 4; v++) begin
            push_run(0, 8);
            slv_stall = (vecs[v].stall > 0);
            start = 1'b1;
            mon_seen = 0;
            tick();
            start = 1'b0;
            check($sformatf("v%0d_busy_after_start", v), 32'(busy), 32'd1);
            check($sformatf("v%0d_done_cleared", v), 32'(done), 32'd0);
            check($sformatf("v%0d_wr_restart", v), 32'(wr_count), 32'd0);
            if (vecs[v].stall > 0) begin
                for (int k = 1; k < vecs[v].stall; k++) tick();
                check($sformatf("v%0d_no_hs_in_stall", v), 32'(mon_seen) + 32'(wr_count), 32'd0);
                slv_stall = 1'b0;
            end
            if (vecs[v].restart_busy) begin
                repeat (6) tick();
                start = 1'b1;
                tick();
                start = 1'b0;
                check($sformatf("v%0d_still_busy", v), 32'(busy), 32'd1);
            end
            wait_done(0, $sformatf("v%0d", v));
            check($sformatf("v%0d_wr_count", v), 32'(wr_count), 32'(vecs[v].exp_wr));
            check($sformatf("v%0d_rd_count", v), 32'(rd_count), 32'(vecs[v].exp_rd));
            check($sformatf("v%0d_err_count", v), 32'(err_count), 32'(vecs[v].exp_err));
            check($sformatf("v%0d_pass", v), 32'(pass), 32'(vecs[v].exp_pass));
            check($sformatf("v%0d_busy_end", v), 32'(busy), 32'd0);
            check($sformatf("v%0d_sb_drained", v), 32'(q1.size()), 32'd0);
            repeat (3) tick();
        end

        // Reset during the read phase aborts the run
        push_run(0, 8);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 0; n < 1000 && rd_count < 8'd2; n++) tick();
        check("midrst_reached_reads", 32'(rd_count >= 8'd2), 32'd1);
        aresetn = 1'b1;
        tick();
        aresetn = 1'b0;
        q1.delete();
        q2.delete();
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_counts", {8'h0, wr_count, rd_count, err_count}, 32'd0);
        tick();
        push_run(0, 8);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(0, "after_rst");
        check("after_rst_counts", {8'h0, wr_count, rd_count, err_count}, {8'h0, 8'd8, 8'd8, 8'd0});
        check("after_rst_pass", 32'(pass), 32'd1);
        check("after_rst_sb_drained", 32'(q1.size()), 32'd0);

        // 20 transactions into a 16-word slave: last four writes and reads error out
        push_run(1, 20);
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        wait_done(1, "oor");
        check("oor_wr_count", 32'(wr_count2), 32'd20);
        check("oor_rd_count", 32'(rd_count2), 32'd20);
        check("oor_err_count", 32'(err_count2), 32'd8);
        check("oor_pass", 32'(pass2), 32'd0);
        check("oor_sb_drained", 32'(q2.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
